// File: rtl/switch_arb_pkg.sv
// Shared types and helpers for the round-robin switch arbiter and its
// leading-ones display path.
package switch_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int VEC_W = 32;

    // Leading-ones code: index of the highest set bit plus one, 0 when empty.
    function automatic logic [5:0] highest_one(input logic [VEC_W-1:0] vec);
        logic [5:0] pos;
        pos = 6'd0;
        for (int i = 0; i < VEC_W; i++) begin
            pos = vec[i] ? 6'(i + 1) : pos;
        end
        return pos;
    endfunction

endpackage

// File: rtl/switch_grant_arbiter_ones_finder.sv
// Combinational highest-set-bit search over a BITS-wide vector.
module ones_finder #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0]         vec,
    output logic                    found,
    output logic [$clog2(BITS)-1:0] index
);

    localparam int IW = $clog2(BITS);

    // Ascending scan: the last hit written is the highest index.
    always_comb begin
        found = 1'b0;
        index = {IW{1'b0}};
        for (int i = 0; i < BITS; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                index = IW'(i);
            end else begin
                found = found;
                index = index;
            end
        end
    end

endmodule

// File: rtl/switch_grant_arbiter.sv
// Round-robin arbiter: leading-ones winner selection rotating downward from the
// previous owner, hold until release/drop/limit, registered one-hot grant.
module switch_grant_arbiter
    import switch_arb_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int MAX_GRANT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BITS-1:0]         req,
    input  logic                    release_grant,  // owner finished
    output logic [BITS-1:0]         grant,
    output logic [$clog2(BITS):0]   grant_id,
    output logic                    busy,
    output logic                    timeout
);

    localparam int IW  = $clog2(BITS);
    localparam int LW  = IW + 1;
    localparam int IDW = IW + 1;
    localparam int HW  = $clog2(MAX_GRANT) + 1;

    localparam logic [BITS-1:0] ONE_VEC   = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]   NO_LAST   = LW'(BITS);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_GRANT - 1);

    arb_state_t      state_r, state_s;
    logic [IW-1:0]   owner_r, owner_s;
    logic [LW-1:0]   last_r, last_s;
    logic [HW-1:0]   hold_r, hold_s;
    logic            limit_r, limit_s;

    logic [BITS-1:0] mask_s;
    logic [BITS-1:0] masked_req_s;
    logic            masked_found_s, any_found_s;
    logic [IW-1:0]   masked_idx_s, any_idx_s, winner_s;
    logic            drop_s, at_limit_s;
    logic [BITS-1:0] grant_s;
    logic [IDW-1:0]  grant_id_s;

    // "No history" opens the mask fully, so the plain leading-ones search wins.
    always_comb begin
        if (last_r >= NO_LAST) begin
            mask_s = {BITS{1'b1}};
        end else begin
            mask_s = (ONE_VEC << last_r) - ONE_VEC;
        end
        masked_req_s = req & mask_s;
    end

    ones_finder #(.BITS(BITS)) u_masked_finder (
        .vec   (masked_req_s),
        .found (masked_found_s),
        .index (masked_idx_s)
    );

    ones_finder #(.BITS(BITS)) u_any_finder (
        .vec   (req),
        .found (any_found_s),
        .index (any_idx_s)
    );

    assign winner_s = masked_found_s ? masked_idx_s : any_idx_s;

    // Next-state logic; a release or drop suppresses the timeout flag.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        last_s     = last_r;
        hold_s     = hold_r;
        limit_s    = 1'b0;
        drop_s     = release_grant || !req[owner_r];
        at_limit_s = (hold_r == HOLD_LAST);
        case (state_r)
            IDLE: begin
                if (any_found_s) begin
                    state_s = GRANT;
                    owner_s = winner_s;
                    hold_s  = {HW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                hold_s = hold_r + {{(HW-1){1'b0}}, 1'b1};
                if (drop_s || at_limit_s) begin
                    state_s = IDLE;
                    last_s  = {1'b0, owner_r};
                    limit_s = !drop_s;
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output images of the current state, registered below.
    always_comb begin
        if (state_r == GRANT) begin
            grant_s = ONE_VEC << owner_r;
        end else begin
            grant_s = {BITS{1'b0}};
        end
        grant_id_s = IDW'(highest_one(VEC_W'(grant_s)));
    end

    // FSM, ownership history and hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= {IW{1'b0}};
            last_r  <= NO_LAST;
            hold_r  <= {HW{1'b0}};
            limit_r <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            last_r  <= last_s;
            hold_r  <= hold_s;
            limit_r <= limit_s;
        end
    end

    // Registered outputs; timeout lands in the same cycle the grant drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant    <= {BITS{1'b0}};
            grant_id <= {IDW{1'b0}};
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            grant    <= grant_s;
            grant_id <= grant_id_s;
            busy     <= (state_r == GRANT);
            timeout  <= limit_r;
        end
    end

endmodule

// File: tb/tb_switch_grant_arbiter.sv
// Directed and random bench for switch_grant_arbiter with a behavioural
// round-robin model feeding an expected-value queue.
module tb_switch_grant_arbiter;

    localparam int BITS      = 16;
    localparam int MAX_GRANT = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [15:0]     req = 16'h0000;
    logic            release_grant = 1'b0;
    logic [15:0]     grant;
    logic [4:0]      grant_id;
    logic            busy;
    logic            timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] g;
        logic [4:0]  id;
        logic        b;
        logic        t;
    } exp_t;

    exp_t exq[$];

    // Behavioural model of the arbiter's internal state
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = BITS;
    int m_cnt   = 0;
    bit m_pend  = 1'b0;

    switch_grant_arbiter #(.BITS(BITS), .MAX_GRANT(MAX_GRANT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .release_grant (release_grant),
        .grant         (grant),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Walk downward from the previous owner, wrapping to the top.
    function automatic int pick(input logic [15:0] r, input int last);
        for (int k = 1; k <= BITS; k++) begin
            int idx;
            idx = (last - k + BITS) % BITS;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_update(input logic [15:0] r, input logic rl, input logic rs);
        bit drop;
        bit lim;
        if (rs) begin
            m_busy = 1'b0; m_last = BITS; m_cnt = 0; m_pend = 1'b0;
        end else if (!m_busy) begin
            m_pend = 1'b0;
            if (r != 16'h0000) begin
                m_owner = pick(r, m_last);
                m_busy  = 1'b1;
                m_cnt   = 0;
            end
        end else begin
            drop = rl || !r[m_owner];
            lim  = (m_cnt == MAX_GRANT - 1);
            m_cnt++;
            if (drop || lim) begin
                m_busy = 1'b0;
                m_last = m_owner;
                m_pend = !drop;
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [15:0] r, input logic rl, input logic rs);
        exp_t e;
        @(negedge clk);
        req = r;
        release_grant = rl;
        reset = rs;
        if (rs) begin
            e = '{g: 16'h0000, id: 5'd0, b: 1'b0, t: 1'b0};
        end else begin
            e.g  = m_busy ? (16'h0001 << m_owner) : 16'h0000;
            e.id = m_busy ? 5'(m_owner + 1) : 5'd0;
            e.b  = m_busy;
            e.t  = m_pend;
        end
        exq.push_back(e);
        model_update(r, rl, rs);
        @(posedge clk);
        #1;
        e = exq.pop_front();
        chk("grant", {16'h0000, grant}, {16'h0000, e.g});
        chk("grant_id", {27'd0, grant_id}, {27'd0, e.id});
        chk("busy", {31'd0, busy}, {31'd0, e.b});
        chk("timeout", {31'd0, timeout}, {31'd0, e.t});
    endtask

    initial begin
        int hi;
        int tos;
        logic [15:0] rr;
        logic        rl;
        logic        rs;

        // Reset and single request
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0010, 1'b0, 1'b0);
        step(16'h0010, 1'b0, 1'b0);
        chk("single_grant", {16'h0, grant}, 32'h0000_0010);
        chk("single_id", {27'd0, grant_id}, 32'd5);
        step(16'h0010, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        chk("single_released", {16'h0, grant}, 32'h0);

        // Rotation between 15 and 0
        step(16'h8001, 1'b0, 1'b1);
        step(16'h8001, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(16'h8001, 1'b0, 1'b0);
            chk("rotate_gap", {16'h0, grant}, 32'h0);
            step(16'h8001, 1'b1, 1'b0);
            chk("rotate_id", {27'd0, grant_id}, (k % 2 == 0) ? 32'd16 : 32'd1);
        end

        // Downward wrap from last=3
        step(16'h0008, 1'b0, 1'b0);
        step(16'h0008, 1'b1, 1'b0);
        step(16'h0028, 1'b0, 1'b0);
        step(16'h0028, 1'b0, 1'b0);
        chk("wrap_id", {27'd0, grant_id}, 32'd6);
        step(16'h0028, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b0);

        // Hold limit
        hi = 0;
        tos = 0;
        for (int i = 0; i < 10; i++) begin
            step(16'h0002, 1'b0, 1'b0);
            if (grant === 16'h0002) hi++;
            if (timeout === 1'b1) tos++;
        end
        chk("hold_cycles", 32'(hi), 32'd8);
        chk("timeout_pulses", 32'(tos), 32'd1);
        step(16'h0002, 1'b0, 1'b0);
        chk("regrant", {16'h0, grant}, 32'h0000_0002);
        step(16'h0002, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b0);

        // Drop without preemption
        step(16'h0080, 1'b0, 1'b0);
        step(16'h0080, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(16'h1080, 1'b0, 1'b0);
            chk("no_preempt", {16'h0, grant}, 32'h0000_0080);
        end
        step(16'h1000, 1'b0, 1'b0);
        chk("drop_hold", {16'h0, grant}, 32'h0000_0080);
        step(16'h1000, 1'b0, 1'b0);
        chk("drop_gap", {16'h0, grant}, 32'h0);
        chk("drop_no_timeout", {31'd0, timeout}, 32'd0);
        step(16'h1000, 1'b0, 1'b0);
        chk("drop_next", {16'h0, grant}, 32'h0000_1000);

        // Reset mid-grant clears history
        step(16'h1000, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0100, 1'b0, 1'b0);
        step(16'h0100, 1'b0, 1'b0);
        chk("pre_reset_grant", {16'h0, grant}, 32'h0000_0100);
        step(16'h0100, 1'b0, 1'b1);
        chk("reset_grant", {16'h0, grant}, 32'h0);
        step(16'h0101, 1'b0, 1'b0);
        step(16'h0101, 1'b0, 1'b0);
        chk("post_reset_id", {27'd0, grant_id}, 32'd9);
        step(16'h0101, 1'b1, 1'b0);

        // Random traffic against the model
        rr = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rr = 16'($urandom) & 16'($urandom);
            end
            rl = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 80) == 0);
            step(rr, rl, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_grant_arbiter.md
# switch_grant_arbiter

Round-robin arbiter that shares one resource among BITS requesters. Requests are presented on a switch-style vector, and the winner is found with leading-ones priority (highest index first). It holds a one-hot grant until the owner releases, drops its request, or exceeds a hold limit. It also reports the owner as a 1-based leading-ones code (0 = none) so it can drive the same LED display as the combinational leading-ones decoder.

## Interface
- BITS, 16, number of requesters; 2..32
- MAX_GRANT, 8, maximum consecutive cycles one owner may hold the grant; ≥1
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  BITS  request vector; req[i]=1 means requester i wants the resource
- release  input  1  current owner is finished; sampled only in GRANT
- grant  output  BITS  one-hot grant; all zero when idle
- grant_id  output  $clog2(BITS)+1  owner index+1; 0 when no grant
- busy  output  1  1 while in GRANT
- timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_GRANT limit

## Operation
- States: IDLE, GRANT (two-state FSM, registered).
- Internal registers:
  - last: index of the previous owner; reset value BITS, meaning no history.
  - owner: index of the current owner.
  - hold_cnt: counter, width $clog2(MAX_GRANT)+1.
- Winner selection (combinational, evaluated in IDLE):
  - masked = req & ((1<<last)-1).
  - If masked≠0, winner = highest set index of masked; otherwise winner = highest set index of req.
  - This rotates priority downward from the last owner and wraps to the top.
- IDLE:
  - If |req: latch owner=winner, clear hold_cnt, go to GRANT.
  - Otherwise stay in IDLE.
  - release is ignored in IDLE.
- GRANT:
  - grant[owner]=1, grant_id=owner+1, busy=1.
  - hold_cnt increments each cycle.
  - Exit to IDLE when release=1, or req[owner]=0, or hold_cnt==MAX_GRANT-1. Exit priority: release/drop over timeout.
  - On exit: last=owner.
  - timeout=1 for one cycle only when exiting solely because of the limit (release=0 and req[owner]=1).
- Requests from non-owners arriving during GRANT never preempt the owner.
- Reset at any point: state=IDLE, last=BITS, hold_cnt=0.
- Reset values of outputs: grant=0, grant_id=0, busy=0, timeout=0.
- A single requester may be re-granted immediately after its own release, subject to the IDLE gap cycle.

## Timing
- All outputs are registered.
- Grant latency: req seen in IDLE at edge N gives grant valid after edge N+1 (1 cycle).
- Exit condition sampled at edge M gives grant=0 after edge M+1. The earliest next grant is after edge M+2, so there is a minimum one-cycle idle gap between owners.
- Maximum hold is MAX_GRANT cycles of grant=1. With MAX_GRANT=1, every grant lasts exactly one cycle and timeout pulses if the owner is still requesting.
- timeout asserts in the same cycle grant drops.
- Simultaneous release and limit: no timeout.
- Simultaneous reset and any event: reset wins.

## Structure
- Package switch_arb_pkg:
  - state enum typedef {IDLE, GRANT}.
  - Function `highest_one(vec)` returning index+1 (0 if none), shared with the display path.
- Sub-module ones_finder: combinational masked highest-set-bit search, parameterised by BITS. It outputs found and index. It is instantiated twice (masked and unmasked) or once with a mux.
- Top holds the FSM, last/owner registers, hold counter, and output registers.

## Test plan
- Reset and single request:
  - Stimulus: reset 2 cycles, then req=16'h0010.
  - Response: all outputs 0 during reset; grant=16'h0010 and grant_id=5 one cycle after req; release gives grant=0 the next cycle.
- Priority and rotation:
  - Stimulus: req=16'h8001 held, release pulsed each grant.
  - Response: owners alternate 15, 0, 15, 0; grant_id sequence 16, 1, 16, 1 with one idle cycle between each.
- Downward wrap:
  - Stimulus: last=3 (grant 3 then release), then req=16'h0028.
  - Response: next owner 5? No: the mask of indices below 3 is empty, so the search wraps and the next owner is 5 (grant_id=6).
- Hold limit, MAX_GRANT=8:
  - Stimulus: req=16'h0002 held, release=0.
  - Response: grant high exactly 8 cycles; timeout pulses once as grant drops; re-granted after 1 idle cycle.
- Request drop and no preemption:
  - Stimulus: owner 7 granted, req[12] rises, then req[7] falls.
  - Response: grant stays 16'h0080 until the cycle after req[7]=0, with no timeout; then 12 is granted.
- Reset mid-grant:
  - Stimulus: assert reset while grant=16'h0100.
  - Response: grant=0 after the next edge; after reset, req=16'h0101 grants 8 (history cleared, highest index wins).
